// File: rtl/clock_enable_synth_if.sv
// Configuration write channel for clock_enable_synth.
// A write is offered with cfg_valid and accepted on a clock edge where
// cfg_ready is also high.
//   cfg_valid  master -> slave  write offered
//   cfg_ready  slave  -> master block can accept a write
//   cfg_ch     master -> slave  target channel
//   cfg_num    master -> slave  ratio numerator
//   cfg_den    master -> slave  ratio denominator
//   cfg_phase  master -> slave  initial accumulator value
interface clock_enable_synth_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CH_W  = 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [WIDTH-1:0] cfg_num;
  logic [WIDTH-1:0] cfg_den;
  logic [WIDTH-1:0] cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_num,
    output cfg_den,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_num,
    input  cfg_den,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/clock_enable_synth.sv
// Fractional clock-enable synthesizer.
// Each of NUM_CH channels produces one-cycle enable pulses at an average
// rate of num/den of clk using a first-order phase accumulator. Channels are
// reprogrammed one at a time through the cfg interface; after every write the
// block spends LOCK_CYCLES enabled cycles settling before `locked` returns.
//   clk     in   single clock
//   rst     in   asynchronous, active-high reset
//   enable  in   global run gate; low freezes accumulators and lock counter
//   cfg     if   configuration write channel (slave side)
//   cen     out  per-channel registered clock-enable pulses
//   locked  out  all channels configured and settled
module clock_enable_synth #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned CH_W        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  clock_enable_synth_if.slave   cfg,
  output logic [NUM_CH-1:0]     cen,
  output logic                  locked
);

  // Lock counter only has to reach LOCK_CYCLES-1; it saturates there.
  localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELOCK = 2'd0,
    S_LOCKED = 2'd1,
    S_LOAD   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LCW-1:0]   r_lock_cnt;
  logic [LCW-1:0]   w_lock_cnt_nxt;
  logic             w_cfg_ready;
  logic             w_locked;
  logic             w_accept;

  // Write captured at the handshake and applied during LOAD.
  logic [CH_W-1:0]  r_ld_ch;
  logic [WIDTH-1:0] r_ld_num;
  logic [WIDTH-1:0] r_ld_den;
  logic [WIDTH-1:0] r_ld_phase;
  logic [WIDTH:0]   w_ld_acc;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RELOCK;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_cfg_ready    = 1'b0;
    w_locked       = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      S_RELOCK: begin
        if (enable) begin
          if (r_lock_cnt == LOCK_LAST) begin
            w_state_nxt = S_LOCKED;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
          end
        end
      end
      S_LOCKED: begin
        w_cfg_ready = 1'b1;
        w_locked    = 1'b1;
        if (cfg.cfg_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_lock_cnt_nxt = '0;
        w_state_nxt    = S_RELOCK;
      end
      default: begin
        w_lock_cnt_nxt = '0;
        w_state_nxt    = S_RELOCK;
      end
    endcase
  end

  assign cfg.cfg_ready = w_cfg_ready;
  assign locked        = w_locked;

  // ---------------------------------------------------------------------------
  // Write capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_ch    <= '0;
      r_ld_num   <= '0;
      r_ld_den   <= '0;
      r_ld_phase <= '0;
    end else if (w_accept) begin
      r_ld_ch    <= cfg.cfg_ch;
      r_ld_num   <= cfg.cfg_num;
      r_ld_den   <= cfg.cfg_den;
      r_ld_phase <= cfg.cfg_phase;
    end
  end

  // A phase at or beyond the new denominator would break the acc < den
  // invariant, so it is folded to zero.
  assign w_ld_acc = (r_ld_phase < r_ld_den) ? {1'b0, r_ld_phase} : '0;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH:0]   r_acc;
    logic             r_cen;
    logic             w_load;
    logic             w_off;
    logic             w_full;
    logic [WIDTH:0]   w_sum;

    // An out-of-range cfg_ch matches no CH_IDX, so the write touches nothing.
    assign w_load = (r_state == S_LOAD) && (r_ld_ch == CH_IDX);
    assign w_off  = (r_num == '0) || (r_den == '0);
    assign w_full = (r_num >= r_den);
    assign w_sum  = r_acc + {1'b0, r_num};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_num <= '0;
        r_den <= WIDTH'(1);
        r_acc <= '0;
        r_cen <= 1'b0;
      end else if (w_load) begin
        // LOAD ignores enable so the sequence always lasts one cycle.
        r_num <= r_ld_num;
        r_den <= r_ld_den;
        r_acc <= w_ld_acc;
        r_cen <= 1'b0;
      end else if (!enable || w_off) begin
        r_cen <= 1'b0;
      end else if (w_full) begin
        r_acc <= '0;
        r_cen <= 1'b1;
      end else if (w_sum >= {1'b0, r_den}) begin
        r_acc <= w_sum - {1'b0, r_den};
        r_cen <= 1'b1;
      end else begin
        r_acc <= w_sum;
        r_cen <= 1'b0;
      end
    end

    assign cen[g] = r_cen;
  end

endmodule

// File: tb/tb_clock_enable_synth.sv
// Directed bench for clock_enable_synth with NUM_CH=3 (so an out-of-range
// cfg_ch=3 is representable), WIDTH=8, LOCK_CYCLES=16.
module tb_clock_enable_synth;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] cen;
  logic       locked;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int m0     = 0;   // enabled edges since ch0 was last loaded with 2/5

  clock_enable_synth_if #(.WIDTH(8), .CH_W(2)) cfg_if ();

  clock_enable_synth #(
    .NUM_CH      (3),
    .WIDTH       (8),
    .LOCK_CYCLES (16),
    .CH_W        (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cfg    (cfg_if),
    .cen    (cen),
    .locked (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (enable) m0++;
    #1;
  endtask

  // 2/5 with phase 0: after the load edge the accumulator runs
  // 2,4,1,3,0,... pulsing when it wraps (m mod 5 == 3 or 0).
  function automatic logic exp5(input int m);
    return (m >= 1) && ((m % 5 == 0) || (m % 5 == 3));
  endfunction

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] num,
                           input logic [7:0] den, input logic [7:0] ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_num   = num;
    cfg_if.cfg_den   = den;
    cfg_if.cfg_phase = ph;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("load locked", locked, 0);
    chk("load ready", cfg_if.cfg_ready, 0);
  endtask

  initial begin
    logic [2:0] e;
    int n2;
    rst = 1'b1;
    enable = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_num   = '0;
    cfg_if.cfg_den   = '0;
    cfg_if.cfg_phase = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst locked", locked, 0);
    chk("rst ready", cfg_if.cfg_ready, 0);
    chk("rst cen", cen, 0);
    rst = 1'b0;

    // Initial lock: 16 edges after release.
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("init locked k=%0d", k), locked, (k == 16));
      chk($sformatf("init ready k=%0d", k), cfg_if.cfg_ready, (k == 16));
      chk($sformatf("init cen k=%0d", k), cen, 0);
    end

    // ch0 1/3 phase 0: pulses on edges 4,7,10,... after handshake.
    cfg_write(2'd0, 8'd1, 8'd3, 8'd0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      e = {2'b00, (j > 1) && ((j - 1) % 3 == 0)};
      chk($sformatf("A cen j=%0d", j), cen, e);
      chk($sformatf("A locked j=%0d", j), locked, (j == 17));
    end

    // ch0 2/5 phase 0.
    cfg_write(2'd0, 8'd2, 8'd5, 8'd0);
    tick();
    m0 = 0;
    chk("B cen load", cen, 0);
    for (int j = 2; j <= 17; j++) begin
      tick();
      chk($sformatf("B cen j=%0d", j), cen, {2'b00, exp5(m0)});
      chk($sformatf("B locked j=%0d", j), locked, (j == 17));
    end

    // ch1 2/5 phase 4: accumulator 4,1,3,0,2,4,... pulses at n mod 5 in {1,3};
    // ch0 keeps its own pattern.
    cfg_write(2'd1, 8'd2, 8'd5, 8'd4);
    for (int j = 1; j <= 17; j++) begin
      tick();
      e = {1'b0, (j > 1) && (((j - 1) % 5 == 1) || ((j - 1) % 5 == 3)), exp5(m0)};
      chk($sformatf("C cen j=%0d", j), cen, e);
      chk($sformatf("C locked j=%0d", j), locked, (j == 17));
    end

    // ch1 rewritten to 7/4: solid high after load; ch0 unbroken.
    cfg_write(2'd1, 8'd7, 8'd4, 8'd0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      e = {1'b0, (j > 1), exp5(m0)};
      chk($sformatf("D cen j=%0d", j), cen, e);
    end

    // ch2 den=0: stays off.
    cfg_write(2'd2, 8'd3, 8'd0, 8'd0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      chk($sformatf("E cen j=%0d", j), cen, {2'b01, exp5(m0)});
    end

    // Out-of-range channel: nothing changes, locked low for LOAD + 16.
    cfg_write(2'd3, 8'd1, 8'd1, 8'd0);
    for (int j = 1; j <= 17; j++) begin
      tick();
      chk($sformatf("F cen j=%0d", j), cen, {2'b01, exp5(m0)});
      chk($sformatf("F locked j=%0d", j), locked, (j == 17));
    end

    // ch2 1/2 phase 1 with enable dropped for edges 7..11 of the relock:
    // lock needs 16 enabled RELOCK edges, so it lands on k=22.
    cfg_write(2'd2, 8'd1, 8'd2, 8'd1);
    n2 = 0;
    for (int k = 1; k <= 22; k++) begin
      enable = !(k >= 7 && k <= 11);
      tick();
      if (k > 1 && enable) n2++;
      e = {enable && (k > 1) && (n2 % 2 == 1), enable, enable && exp5(m0)};
      chk($sformatf("G cen k=%0d", k), cen, e);
      chk($sformatf("G locked k=%0d", k), locked, (k == 22));
    end
    enable = 1'b1;

    // Reset in RELOCK after a write: immediate clear, channels off afterwards.
    cfg_write(2'd0, 8'd1, 8'd1, 8'd0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("H rst locked", locked, 0);
    chk("H rst ready", cfg_if.cfg_ready, 0);
    chk("H rst cen", cen, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk($sformatf("H cen k=%0d", k), cen, 0);
      chk($sformatf("H locked k=%0d", k), locked, (k >= 16));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
